delay_line_ctrl: RTL and testbench
==================================

# delay_line_ctrl

Measurement sequencer for the tapped delay line: launches an edge into the line, samples the tap snapshot one clock period later, and decodes how far the edge travelled. It averages 2^AVG_LOG2 samples and returns the result over a valid/ready handshake. It sits between the top-level pin wrapper (start/ena/readout) and the raw delay-line macro.

## Interface
Parameters:
- TAPS, 32, number of delay-line taps (≥2)
- SETTLE, 4, idle cycles after each sample so the line fully propagates (≥1)
- AVG_LOG2, 3, log2 of samples averaged per measurement (0..6)

Ports (CW = $clog2(TAPS+1)):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  block enable; low aborts any measurement
- start  in  1  measurement request, sampled in IDLE only
- taps  in  TAPS  raw asynchronous tap outputs, tap 0 nearest launch
- launch  out  1  registered drive into delay-line input
- busy  out  1  high from start acceptance until return to IDLE
- result  out  CW  averaged tap count
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- err  out  2  {sat, bubble}, sticky per measurement, valid with result

## Operation
- States: IDLE, FIRE, SYNC, EVAL, SETTLE, DONE.
- IDLE: start & ena → launch toggles, acc/n/err cleared, → FIRE.
- FIRE: cap0 <= taps (edge has had exactly one clk period) → SYNC.
- SYNC: cap1 <= cap0 (second metastability flop) → EVAL.
- EVAL: decode cap1 against pol = current launch. code = count of consecutive taps from tap 0 equal to pol. bubble = any tap equal to pol beyond the first mismatch. sat = (code == TAPS). acc += code, err |= {sat,bubble}, n++ → SETTLE.
- SETTLE: count SETTLE cycles, then: n == 2^AVG_LOG2 → DONE with result = acc >> AVG_LOG2 (truncate); else toggle launch → FIRE.
- Launch alternates polarity every sample; rising and falling edges are both measured.
- DONE: result_valid=1, result/err held stable until result_valid & result_ready → IDLE. start ignored outside IDLE, including the handshake cycle.
- acc width CW+AVG_LOG2, never overflows. n width AVG_LOG2+1.
- ena low in any state other than IDLE/DONE → IDLE next edge, no result_valid. acc is discarded; launch keeps its level. ena low in DONE does not drop valid.

## Timing
- Reset values: launch=0, busy=0, result=0, result_valid=0, err=0, state IDLE. Asynchronous assertion takes effect immediately mid-measurement.
- All outputs registered; busy = (state != IDLE).
- Per sample: SETTLE+3 cycles (FIRE, SYNC, EVAL, SETTLE×SETTLE).
- Start accepted at edge E0 → result_valid high from edge E0 + 2^AVG_LOG2·(SETTLE+3). Defaults: 56 cycles.
- launch toggles only on the edge entering FIRE; never twice within SETTLE+3 cycles.
- Back-to-back: IDLE at the edge after the handshake, start accepted at the following edge.

## Structure
- delay_line_pkg: state enum, code-width function clog2(TAPS+1), err bit indices.
- Sub-module delay_line_decode: combinational; inputs cap1 and pol, outputs code, bubble, sat. Parameterised by TAPS.
- Controller holds the FSM, cap0/cap1, accumulator, counters, launch flop.

## Test plan
Defaults TAPS=32, SETTLE=4, AVG_LOG2=3; line model: taps[i] follows launch after i·Δ.
- Reset: rst pulsed at cycle 20 of a measurement → launch, busy, result_valid, result, err = 0 asynchronously; next start runs a clean 56-cycle measurement.
- Ideal line, 10 taps per period on both polarities: start → result_valid at E0+56, result=10, err=00, launch toggled 8 times.
- Asymmetric edges: rising 8 taps, falling 11 taps → sum 76, result=9, err=00.
- Bubble: one sample with taps 0–9 matching, 10 mismatching, 12 matching → that code=10, err=01.
- Saturation: clk period longer than line, all 32 taps match → result=32, err=10.
- Handshake and abort: result_ready low 5 cycles → result_valid and result stable, start pulses ignored. ena dropped at cycle 15 of the next run → busy low one edge later, no result_valid. Re-raising ena plus start gives a full measurement.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the tapped-delay-line measurement sequencer.
// Holds the FSM state encoding, the tap-count width helper and the err bit positions.
package delay_line_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_SYNC,
        ST_EVAL,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int ERR_BUBBLE = 0;
    localparam int ERR_SAT    = 1;

    // Width needed to hold a tap count in 0..taps inclusive.
    function automatic int code_width(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/delay_line_decode.sv
// Thermometer decoder for one captured tap snapshot.
// Counts the leading run of taps equal to the launch polarity and flags bubbles/saturation.
module delay_line_decode
    import delay_line_pkg::*;
#(
    parameter int TAPS = 32,
    localparam int CW = code_width(TAPS)
) (
    input  logic [TAPS-1:0] cap,
    input  logic            pol,
    output logic [CW-1:0]   code,
    output logic            bubble,
    output logic            sat
);

    logic [TAPS-1:0] match;
    logic            in_run;

    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_match
            assign match[gi] = (cap[gi] == pol);
        end
    endgenerate

    // A matching tap after the run has been broken is a bubble, not extra distance.
    always_comb begin
        in_run = 1'b1;
        code   = '0;
        bubble = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (in_run && match[i]) begin
                code = code + CW'(1);
            end else begin
                in_run = 1'b0;
                if (match[i]) begin
                    bubble = 1'b1;
                end
            end
        end
    end

    assign sat = (code == CW'(TAPS));

endmodule

// File: rtl/delay_line_ctrl.sv
// Delay-line measurement sequencer: launches alternating edges, double-flops the tap
// snapshot, decodes it and averages 2^AVG_LOG2 samples into a valid/ready result.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int TAPS     = 32,
    parameter int SETTLE   = 4,
    parameter int AVG_LOG2 = 3,
    localparam int CW = code_width(TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            start,
    input  logic [TAPS-1:0] taps,
    output logic            launch,
    output logic            busy,
    output logic [CW-1:0]   result,
    output logic            result_valid,
    input  logic            result_ready,
    output logic [1:0]      err
);

    localparam int AW = CW + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [NW-1:0] N_TARGET    = NW'(2 ** AVG_LOG2);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    state_t          state_reg, state_next;
    logic [TAPS-1:0] cap0_reg, cap1_reg;
    logic [AW-1:0]   acc_reg;
    logic [NW-1:0]   n_reg;
    logic [SW-1:0]   settle_cnt_reg;
    logic            launch_reg;
    logic            busy_reg;
    logic            valid_reg;
    logic [CW-1:0]   result_reg;
    logic [1:0]      err_reg;
    logic [CW-1:0]   code;
    logic            bubble;
    logic            sat;

    delay_line_decode #(.TAPS(TAPS)) u_decode (
        .cap    (cap1_reg),
        .pol    (launch_reg),
        .code   (code),
        .bubble (bubble),
        .sat    (sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start && ena) state_next = ST_FIRE;
            ST_FIRE:   state_next = ST_SYNC;
            ST_SYNC:   state_next = ST_EVAL;
            ST_EVAL:   state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (settle_cnt_reg == SETTLE_LAST) begin
                    if (n_reg == N_TARGET) state_next = ST_DONE;
                    else                   state_next = ST_FIRE;
                end
            end
            ST_DONE:   if (result_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        // Dropping ena abandons an in-flight measurement but never a finished result.
        if (!ena && state_reg != ST_IDLE && state_reg != ST_DONE) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap0_reg       <= '0;
            cap1_reg       <= '0;
            acc_reg        <= '0;
            n_reg          <= '0;
            settle_cnt_reg <= '0;
            launch_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            valid_reg      <= 1'b0;
            result_reg     <= '0;
            err_reg        <= '0;
        end else begin
            busy_reg  <= (state_next != ST_IDLE);
            valid_reg <= (state_next == ST_DONE);
            // FIRE is only ever entered from IDLE or SETTLE, so this is one toggle per sample.
            if (state_next == ST_FIRE) begin
                launch_reg <= ~launch_reg;
            end
            if (state_reg == ST_IDLE && state_next == ST_FIRE) begin
                acc_reg <= '0;
                n_reg   <= '0;
                err_reg <= '0;
            end
            if (state_reg == ST_FIRE) begin
                cap0_reg <= taps;
            end
            if (state_reg == ST_SYNC) begin
                cap1_reg <= cap0_reg;
            end
            if (state_reg == ST_EVAL) begin
                acc_reg             <= acc_reg + AW'(code);
                n_reg               <= n_reg + NW'(1);
                err_reg[ERR_SAT]    <= err_reg[ERR_SAT] | sat;
                err_reg[ERR_BUBBLE] <= err_reg[ERR_BUBBLE] | bubble;
                settle_cnt_reg      <= '0;
            end
            if (state_reg == ST_SETTLE) begin
                settle_cnt_reg <= settle_cnt_reg + SW'(1);
            end
            if (state_reg == ST_SETTLE && state_next == ST_DONE) begin
                result_reg <= CW'(acc_reg >> AVG_LOG2);
            end
        end
    end

    assign launch       = launch_reg;
    assign busy         = busy_reg;
    assign result       = result_reg;
    assign result_valid = valid_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed + randomized bench for delay_line_ctrl with a per-sample tap-pattern line model.
module tb_delay_line_ctrl;

    localparam int TAPS = 32;
    localparam int NS   = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ena = 1'b1;
    logic            start = 1'b0;
    logic [TAPS-1:0] taps;
    logic            launch;
    logic            busy;
    logic [5:0]      result;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [1:0]      err;

    int vectors = 0;
    int errs    = 0;

    // Line model: pat[s] has a 1 for every tap that already shows the new polarity in sample s.
    logic [TAPS-1:0] pat [NS];
    int              idx = 0;
    int              kk  [NS];
    int              bpos[NS];
    int              exp_result;
    int              exp_err;

    always #5 clk = ~clk;

    always @(launch) idx = idx + 1;

    assign taps = launch ? pat[idx[2:0]] : ~pat[idx[2:0]];

    delay_line_ctrl #(.TAPS(TAPS), .SETTLE(4), .AVG_LOG2(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .start        (start),
        .taps         (taps),
        .launch       (launch),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .err          (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds patterns from kk/bpos and derives the expected average/err from the
    // travel distances directly: code = kk, bubble iff an extra tap was injected.
    task automatic build_and_predict();
        int  sum;
        bit  any_sat, any_bub;
        sum = 0; any_sat = 0; any_bub = 0;
        for (int s = 0; s < NS; s++) begin
            pat[s] = '0;
            for (int j = 0; j < kk[s]; j++) pat[s][j] = 1'b1;
            if (bpos[s] >= 0) begin
                pat[s][bpos[s]] = 1'b1;
                any_bub = 1;
            end
            sum += kk[s];
            if (kk[s] == TAPS) any_sat = 1;
        end
        exp_result = sum / NS;
        exp_err    = (any_sat ? 2 : 0) + (any_bub ? 1 : 0);
    endtask

    task automatic set_uniform(input int k);
        for (int s = 0; s < NS; s++) begin
            kk[s] = k;
            bpos[s] = -1;
        end
    endtask

    task automatic run_meas(input string tag);
        build_and_predict();
        idx = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "/busy"}, 32'(busy), 32'd1);
        repeat (55) step();
        check({tag, "/valid_early"}, 32'(result_valid), 32'd0);
        step();
        check({tag, "/valid"}, 32'(result_valid), 32'd1);
        check({tag, "/result"}, 32'(result), 32'(exp_result));
        check({tag, "/err"}, 32'(err), 32'(exp_err));
        check({tag, "/toggles"}, 32'(idx + 1), 32'd8);
        $display("meas %s: result=%0d err=%0b expected result=%0d err=%0b",
                 tag, result, err, exp_result, exp_err);
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, "/hs_valid"}, 32'(result_valid), 32'd0);
        check({tag, "/hs_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bit saw_valid;
        set_uniform(10);
        build_and_predict();

        // Reset values
        step(); step();
        rst = 1'b0;
        step();
        check("rst/launch", 32'(launch), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/valid", 32'(result_valid), 32'd0);
        check("rst/result", 32'(result), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        $display("reset: launch=%0b busy=%0b valid=%0b", launch, busy, result_valid);

        // Asynchronous reset 20 cycles into a measurement
        idx = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("midrst/launch_before", 32'(launch), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst/launch", 32'(launch), 32'd0);
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/valid", 32'(result_valid), 32'd0);
        check("midrst/result", 32'(result), 32'd0);
        check("midrst/err", 32'(err), 32'd0);
        $display("midrst: launch=%0b busy=%0b", launch, busy);
        step();
        rst = 1'b0;
        step();

        // Ideal line
        set_uniform(10);
        run_meas("ideal");
        accept("ideal");

        // Asymmetric edges: rising samples (even) 8 taps, falling (odd) 11 taps
        for (int s = 0; s < NS; s++) begin
            kk[s] = (s % 2 == 0) ? 8 : 11;
            bpos[s] = -1;
        end
        run_meas("asym");
        accept("asym");

        // Single bubble
        set_uniform(10);
        bpos[3] = 12;
        run_meas("bubble");
        accept("bubble");

        // Saturation
        set_uniform(32);
        run_meas("sat");
        accept("sat");

        // Randomized samples
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < NS; s++) begin
                kk[s] = $urandom_range(0, 32);
                bpos[s] = -1;
                if (kk[s] <= 30 && $urandom_range(0, 3) == 0)
                    bpos[s] = kk[s] + 1 + $urandom_range(0, 30 - kk[s]);
            end
            run_meas($sformatf("rand%0d", r));
            accept($sformatf("rand%0d", r));
        end

        // Handshake hold with ignored start pulses
        set_uniform(10);
        run_meas("hold");
        for (int c = 0; c < 5; c++) begin
            start = (c % 2 == 0);
            step();
            check($sformatf("hold%0d/valid", c), 32'(result_valid), 32'd1);
            check($sformatf("hold%0d/result", c), 32'(result), 32'(exp_result));
            check($sformatf("hold%0d/busy", c), 32'(busy), 32'd1);
        end
        // start held through the handshake edge must only be taken on the following edge
        idx = -1;
        start = 1'b1;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("b2b/hs_valid", 32'(result_valid), 32'd0);
        check("b2b/hs_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        check("b2b/accept_busy", 32'(busy), 32'd1);
        $display("back-to-back: busy=%0b after accept edge", busy);

        // Abort with ena low at cycle 15 of this run
        repeat (14) step();
        ena = 1'b0;
        step();
        check("abort/busy", 32'(busy), 32'd0);
        saw_valid = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (result_valid) saw_valid = 1;
        end
        check("abort/no_valid", 32'(saw_valid), 32'd0);
        $display("abort: busy=%0b saw_valid=%0b", busy, saw_valid);
        ena = 1'b1;
        step();
        set_uniform(13);
        run_meas("after_abort");
        accept("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
